// File: rtl/draw_arbiter.sv
// rtl/draw_arbiter.sv - arbitrates three cell-draw clients onto one pixel port and generates the move tick
module draw_arbiter #(
  parameter int BLOCK_LOG2 = 2,
  parameter int TICK_DIV   = 12500000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  output logic        step,
  input  logic [2:0]  req,
  input  logic [23:0] req_x,
  input  logic [20:0] req_y,
  input  logic [8:0]  req_colour,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic        busy,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic [2:0]  colour,
  output logic        plot
);

  localparam int CW = 2 * BLOCK_LOG2;
  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      win;
  logic [7:0]      bx;
  logic [6:0]      by;
  logic [2:0]      bcol;
  logic [TW-1:0]   tcnt;
  logic            tc_wrap;
  logic [2:0]      pick;
  logic [1:0]      pick_idx;
  logic [7:0]      x_sum;
  logic [6:0]      y_sum;

  // Erase wins over head so a head landing on the old tail is painted last.
  always_comb begin
    pick     = 3'b000;
    pick_idx = 2'd0;
    if (req[0]) begin
      pick     = 3'b001;
      pick_idx = 2'd0;
    end else if (req[1]) begin
      pick     = 3'b010;
      pick_idx = 2'd1;
    end else if (req[2]) begin
      pick     = 3'b100;
      pick_idx = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = DRAW;
      DRAW:    if (cnt == '1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt  <= '0;
      win  <= 3'b000;
      bx   <= 8'd0;
      by   <= 7'd0;
      bcol <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            win  <= pick;
            bx   <= req_x[8*pick_idx +: 8];
            by   <= req_y[7*pick_idx +: 7];
            bcol <= req_colour[3*pick_idx +: 3];
            cnt  <= '0;
          end
        end
        DRAW:    cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign x_sum = bx + 8'(cnt[BLOCK_LOG2-1:0]);
  assign y_sum = by + 7'(cnt[CW-1:BLOCK_LOG2]);

  always_comb begin
    grant  = 3'b000;
    done   = 3'b000;
    busy   = 1'b0;
    x_out  = 8'd0;
    y_out  = 7'd0;
    colour = 3'd0;
    plot   = 1'b0;
    case (state)
      DRAW: begin
        grant  = win;
        busy   = 1'b1;
        x_out  = x_sum;
        y_out  = y_sum;
        colour = bcol;
        // Off-screen pixels still consume their slot; only the write is suppressed.
        plot   = (x_sum < 8'd160) && (y_sum < 7'd120);
      end
      DONE: begin
        grant = win;
        done  = win;
        busy  = 1'b1;
      end
      default: ;
    endcase
  end

  assign tc_wrap = (tcnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!resetn)     tcnt <= '0;
    else if (enable) tcnt <= tc_wrap ? '0 : tcnt + 1'b1;
  end

  assign step = resetn && enable && tc_wrap;

endmodule

// File: tb/tb_draw_arbiter.sv
// tb/tb_draw_arbiter.sv - directed self-checking bench for draw_arbiter
module tb_draw_arbiter;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic        step;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_colour;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        busy;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour;
  logic        plot;

  int checks = 0;
  int errors = 0;

  draw_arbiter #(.BLOCK_LOG2(2), .TICK_DIV(4)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .step(step),
    .req(req), .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .grant(grant), .done(done), .busy(busy),
    .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
    logic [2:0] gnt;
    int         nplot;
  } vec_t;

  vec_t vt[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " grant"},  32'(grant),  32'd0);
    chk({tag, " done"},   32'(done),   32'd0);
    chk({tag, " busy"},   32'(busy),   32'd0);
    chk({tag, " plot"},   32'(plot),   32'd0);
    chk({tag, " x_out"},  32'(x_out),  32'd0);
    chk({tag, " y_out"},  32'(y_out),  32'd0);
    chk({tag, " colour"}, 32'(colour), 32'd0);
  endtask

  // Winner channel gets the vector values, the others get decoys.
  task automatic drive_req(input logic [2:0] r, input int w, input logic [7:0] x,
                           input logic [6:0] y, input logic [2:0] c);
    for (int i = 0; i < 3; i++) begin
      req_x[8*i +: 8]      = (i == w) ? x : (x ^ 8'h5a);
      req_y[7*i +: 7]      = (i == w) ? y : (y ^ 7'h2b);
      req_colour[3*i +: 3] = (i == w) ? c : (c ^ 3'b111);
    end
    req = r;
  endtask

  task automatic burst(input vec_t v, input string tag, input bit mutate);
    int w;
    int np;
    logic [7:0] ex;
    logic [6:0] ey;
    logic       ep;
    w  = (v.gnt == 3'b001) ? 0 : (v.gnt == 3'b010) ? 1 : 2;
    np = 0;
    drive_req(v.req, w, v.x, v.y, v.col);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (mutate && k == 3) drive_req(3'b000, w, 8'd100, 7'd60, ~v.col);
      ex = 8'(v.x + 8'((k - 1) % 4));
      ey = 7'(v.y + 7'((k - 1) / 4));
      ep = (ex < 8'd160) && (ey < 7'd120);
      chk($sformatf("%s grant k%0d", tag, k),  32'(grant),  32'(v.gnt));
      chk($sformatf("%s busy k%0d", tag, k),   32'(busy),   32'd1);
      chk($sformatf("%s x k%0d", tag, k),      32'(x_out),  32'(ex));
      chk($sformatf("%s y k%0d", tag, k),      32'(y_out),  32'(ey));
      chk($sformatf("%s colour k%0d", tag, k), 32'(colour), 32'(v.col));
      chk($sformatf("%s plot k%0d", tag, k),   32'(plot),   32'(ep));
      chk($sformatf("%s done k%0d", tag, k),   32'(done),   32'd0);
      if (plot === 1'b1) np++;
    end
    tick();
    chk({tag, " done pulse"}, 32'(done),  32'(v.gnt));
    chk({tag, " done plot"},  32'(plot),  32'd0);
    chk({tag, " done grant"}, 32'(grant), 32'(v.gnt));
    req = 3'b000;
    tick();
    chk({tag, " end busy"},  32'(busy),  32'd0);
    chk({tag, " end grant"}, 32'(grant), 32'd0);
    chk({tag, " end done"},  32'(done),  32'd0);
    chk({tag, " plot count"}, 32'(np), 32'(v.nplot));
  endtask

  initial begin
    int first[3];
    logic [2:0] last;
    int n;
    bit exp_step;

    vt[0] = '{req: 3'b010, x: 8'd40,  y: 7'd20,  col: 3'b100, gnt: 3'b010, nplot: 16};
    vt[1] = '{req: 3'b010, x: 8'd158, y: 7'd118, col: 3'b011, gnt: 3'b010, nplot: 4};
    vt[2] = '{req: 3'b110, x: 8'd10,  y: 7'd5,   col: 3'b001, gnt: 3'b010, nplot: 16};
    vt[3] = '{req: 3'b100, x: 8'd255, y: 7'd127, col: 3'b110, gnt: 3'b100, nplot: 9};
    vt[4] = '{req: 3'b001, x: 8'd156, y: 7'd116, col: 3'b111, gnt: 3'b001, nplot: 16};
    vt[5] = '{req: 3'b011, x: 8'd159, y: 7'd0,   col: 3'b010, gnt: 3'b001, nplot: 4};

    resetn = 1'b0;
    enable = 1'b0;
    drive_req(3'b111, 0, 8'd12, 7'd34, 3'b101);
    tick();
    tick();
    chk_idle_zero("reset");
    chk("reset step", 32'(step), 32'd0);

    resetn = 1'b1;
    tick();
    chk("release grant", 32'(grant), 32'b001);
    chk("release busy",  32'(busy),  32'd1);
    req = 3'b000;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("release drain", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) burst(vt[i], $sformatf("vec%0d", i), 1'b0);

    // All three requesting: each drops its bit on seeing done.
    first = '{-1, -1, -1};
    last  = 3'b000;
    drive_req(3'b111, 0, 8'd20, 7'd20, 3'b001);
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (grant != 3'b000 && grant != last) begin
        if (grant == 3'b001) first[0] = c;
        if (grant == 3'b010) first[1] = c;
        if (grant == 3'b100) first[2] = c;
      end
      last = grant;
      if (done != 3'b000) req = req & ~done;
    end
    chk("prio tail start", 32'(first[0]), 32'd1);
    chk("prio head start", 32'(first[1]), 32'd19);
    chk("prio food start", 32'(first[2]), 32'd37);
    chk("prio drained", 32'(busy), 32'd0);

    burst(vt[0], "mutate", 1'b1);

    drive_req(3'b010, 1, 8'd40, 7'd20, 3'b100);
    for (int k = 1; k <= 8; k++) tick();
    chk("midrst busy pre", 32'(busy), 32'd1);
    resetn = 1'b0;
    req = 3'b000;
    tick();
    chk_idle_zero("midrst");
    resetn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("midrst no done %0d", k), 32'(done | {2'b00, busy}), 32'd0);
    end

    resetn = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("step in reset %0d", k), 32'(step), 32'd0);
    end
    resetn = 1'b1;
    for (int m = 0; m < 24; m++) begin
      enable = !(m >= 12 && m <= 14);
      #1;
      exp_step = (m == 3) || (m == 7) || (m == 11) || (m == 18) || (m == 22);
      chk($sformatf("step n%0d", m), 32'(step), 32'(exp_step));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_arbiter.md
# draw_arbiter

Shares the single pixel-write port of `vga_adapter` (160x120, 3-bit colour) between the snake game's three drawing clients: tail erase, head draw and food draw. It grants one requester at a time, expands the granted cell origin into a BLOCK x BLOCK burst of plotted pixels, and returns a completion pulse. It also produces the game's move tick, so the datapath advances the snake once per tick and then issues its draw requests.

## Interface
- `BLOCK_LOG2`, default 2: cell edge is 2^BLOCK_LOG2 pixels, so cell size is 4x4 by default.
- `TICK_DIV`, default 12500000: number of enabled clock cycles per `step` pulse. Minimum 2.

- `clk`  in  1  system clock (CLOCK_50).
- `resetn`  in  1  reset; one clock; synchronous, active-low.
- `enable`  in  1  tick counter advances only while 1.
- `step`  out  1  one-cycle move-tick pulse.
- `req`  in  3  draw requests. Bit 0 = tail erase, bit 1 = head, bit 2 = food.
- `req_x`  in  24  three packed 8-bit cell-origin x values; requester i uses bits [8i+7:8i].
- `req_y`  in  21  three packed 7-bit cell-origin y values; requester i uses bits [7i+6:7i].
- `req_colour`  in  9  three packed 3-bit colours; requester i uses bits [3i+2:3i].
- `grant`  out  3  one-hot; held for the whole burst.
- `done`  out  3  one-hot, one-cycle completion pulse to the granted requester.
- `busy`  out  1  high whenever the block is not IDLE.
- `x_out`  out  8  pixel x to the adapter.
- `y_out`  out  7  pixel y to the adapter.
- `colour`  out  3  pixel colour to the adapter.
- `plot`  out  1  pixel write enable to the adapter.

## Operation
- FSM states are IDLE, DRAW and DONE.
- **IDLE:** if any `req` bit is high, choose the winner by fixed priority, bit 0 > bit 1 > bit 2.
  - Erase goes before head, so a head overlapping the old tail is drawn last and stays visible.
  - Latch the winner's x, y and colour, clear the pixel counter, and go to DRAW.
  - If no `req` bit is high, stay in IDLE.
- **DRAW:** counter `cnt` has 2*BLOCK_LOG2 bits.
  - `x_out` = bx + cnt[BLOCK_LOG2-1:0].
  - `y_out` = by + cnt[2*BLOCK_LOG2-1:BLOCK_LOG2].
  - Sums are truncated to 8 bits (x) and 7 bits (y).
  - `colour` = latched colour; `cnt` increments every cycle.
  - When `cnt` reaches all-ones, go to DONE.
- **Clipping:** `plot` = 1 in DRAW only when `x_out` < 160 and `y_out` < 120. An off-screen pixel still uses its counter slot, so burst length is always fixed.
- **DONE:** `done[winner]` = 1 and `plot` = 0. Next state is IDLE.
- `grant[winner]` is high throughout DRAW and DONE, and 0 in IDLE.
- Requests and their x/y/colour are sampled only in IDLE. Changes during a burst are ignored, and a `req` dropped mid-burst does not abort it.
- Requesters must deassert `req` on the cycle after seeing `done`. If `req` is still high in IDLE, it is treated as a new request.
- **Tick counter** `tcnt`, ceil(log2(TICK_DIV)) bits:
  - When `enable` = 1: if `tcnt` == TICK_DIV-1, then `tcnt` <= 0 and `step` is 1 for that cycle; otherwise `tcnt` increments.
  - When `enable` = 0: `tcnt` holds and `step` = 0.
  - The tick counter is independent of the FSM. A step during a burst does not stall or reset the burst.
- **Reset:** values are asserted on the first edge with `resetn` = 0.
  - State = IDLE, `cnt` = 0, `tcnt` = 0.
  - `grant`, `done`, `busy`, `plot`, `step`, `x_out`, `y_out` and `colour` are all 0.
  - Reset mid-burst aborts the burst with no `done` pulse.

## Timing
- `grant`, `done`, `busy`, `plot`, `x_out`, `y_out` and `colour` are decoded from registered state only; there are no combinational paths from `req`.
- Request seen in IDLE at cycle t:
  - `grant` and `busy` go high at t+1.
  - First pixel (cnt = 0) is at t+1; last pixel (cnt = 2^(2*BLOCK_LOG2)-1) is at t+16 for the default BLOCK_LOG2.
  - `done` is at t+17; state returns to IDLE at t+18.
  - A next pending request is granted at t+19.
- Back-to-back service of all three requesters therefore takes 3 x 18 = 54 cycles per step at the default size.
- Pixel order is row-major: x varies fastest.

## Test plan
- **Reset:** hold `resetn` = 0 for 2 cycles with `req` = 3'b111 -> all outputs 0, `grant` = 0. Release -> `grant` = 3'b001 one cycle after the first IDLE sample.
- **Single head draw:** `req` = 3'b010, x = 40, y = 20, colour = 3'b100 at cycle t.
  - Pixels (40,20), (41,20), ... , (43,23) appear at t+1..t+16 with `plot` = 1.
  - `done` = 3'b010 at t+17; `busy` low at t+18.
- **Priority:** `req` = 3'b111 held, each bit dropped after its `done` -> grant order 001, 010, 100, with grants starting at t+1, t+19 and t+37.
- **Clipping:** head at x = 158, y = 118 -> `plot` = 1 only for x in {158,159} and y in {118,119}, i.e. 4 of 16 pixels. `done` is still at t+17.
- **Mid-burst change and reset:**
  - Change `req_x` and drop `req` during DRAW -> burst completes unchanged.
  - Separately, assert `resetn` = 0 at t+8 -> no `done`, all outputs 0 at t+9.
- **Tick, with TICK_DIV = 4:**
  - `enable` = 1 -> `step` pulses every 4th cycle.
  - `enable` = 0 for 3 cycles in the middle -> the next pulse is delayed by exactly 3 cycles.
  - No `step` while `resetn` = 0.
